// File: rtl/cirno9_timer.sv
// cirno9_timer: memory-mapped 64-bit machine timer (mtime / mtimecmp) on the IOB.
// A two-state responder answers every access with a one-cycle iob_rdy pulse,
// one cycle after iob_val is first seen. A prescaler gates the mtime
// increment. timer_irq is a registered level compare of mtime >= mtimecmp.
module cirno9_timer #(
  parameter int          DIV_W   = 8,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iob_val,
  output logic        iob_rdy,
  input  logic [31:0] iob_adr,
  input  logic [3:0]  iob_wen,
  input  logic [31:0] iob_wdat,
  output logic [31:0] iob_rdat,
  output logic        timer_irq
);

  // Word offsets decoded from iob_adr[4:2]
  localparam logic [2:0] A_MTIME_LO = 3'd0;
  localparam logic [2:0] A_MTIME_HI = 3'd1;
  localparam logic [2:0] A_CMP_LO   = 3'd2;
  localparam logic [2:0] A_CMP_HI   = 3'd3;
  localparam logic [2:0] A_CTRL     = 3'd4;
  localparam logic [2:0] A_STATUS   = 3'd5;

  typedef enum logic {IDLE, RESP} state_t;

  state_t             state_q, state_d;
  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        cmp_q, cmp_d;
  logic               en_q, en_d;
  logic               ie_q, ie_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic [31:0]        shadow_q, shadow_d;
  logic               rdy_q, rdy_d;
  logic [31:0]        rdat_q, rdat_d;
  logic               irq_q, irq_d;

  logic               acc;
  logic               wr;
  logic               rd;
  logic [2:0]         sel;
  logic [31:0]        wmask;
  logic [31:0]        ctrl_rd;
  logic [31:0]        ctrl_w;
  logic [31:0]        rd_data;
  logic               match;
  logic               tick;
  logic               ctrl_wr;

  // Bits of the address and of the merged CTRL word that carry no meaning
  logic               unused_bits;
  assign unused_bits = ^{iob_adr[31:5], iob_adr[1:0], ctrl_w[31:8+DIV_W], ctrl_w[7:2]};

  // Expand per-byte strobes into a bit mask
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wmask
      assign wmask[8*gi +: 8] = {8{iob_wen[gi]}};
    end
  endgenerate

  // Merge strobed bytes of wdat into an existing word
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] mask,
                                              input logic [31:0] wdat);
    merge_bytes = (old_word & ~mask) | (wdat & mask);
  endfunction

  // An access is only accepted in IDLE; RESP ignores iob_val entirely
  assign acc     = (state_q == IDLE) && iob_val;
  assign wr      = acc && (iob_wen != 4'b0000);
  assign rd      = acc && (iob_wen == 4'b0000);
  assign sel     = iob_adr[4:2];
  assign ctrl_wr = wr && (sel == A_CTRL);

  assign ctrl_rd = {{(24-DIV_W){1'b0}}, div_q, 6'b0, ie_q, en_q};
  assign ctrl_w  = merge_bytes(ctrl_rd, wmask, iob_wdat);

  assign match   = (mtime_q >= cmp_q);
  assign tick    = en_q && (presc_q == div_q);

  // Read-data multiplexer for the addressed register
  always_comb begin
    rd_data = 32'h0;
    case (sel)
      A_MTIME_LO: rd_data = mtime_q[31:0];
      A_MTIME_HI: rd_data = shadow_q;
      A_CMP_LO:   rd_data = cmp_q[31:0];
      A_CMP_HI:   rd_data = cmp_q[63:32];
      A_CTRL:     rd_data = ctrl_rd;
      A_STATUS:   rd_data = {31'b0, match};
      default:    rd_data = 32'h0;
    endcase
  end

  // Response FSM next-state and outputs: rdy/rdat pulse for exactly one cycle
  always_comb begin
    state_d = state_q;
    rdy_d   = 1'b0;
    rdat_d  = 32'h0;
    case (state_q)
      IDLE: begin
        if (iob_val) begin
          rdy_d   = 1'b1;
          rdat_d  = rd_data;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Timer register next-state: software writes win over the tick increment
  always_comb begin
    mtime_d  = mtime_q;
    cmp_d    = cmp_q;
    en_d     = en_q;
    ie_d     = ie_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    presc_d  = presc_q;

    if (wr && (sel == A_MTIME_LO)) begin
      mtime_d[31:0] = merge_bytes(mtime_q[31:0], wmask, iob_wdat);
    end else if (wr && (sel == A_MTIME_HI)) begin
      mtime_d[63:32] = merge_bytes(mtime_q[63:32], wmask, iob_wdat);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr && (sel == A_CMP_LO)) begin
      cmp_d[31:0] = merge_bytes(cmp_q[31:0], wmask, iob_wdat);
    end
    if (wr && (sel == A_CMP_HI)) begin
      cmp_d[63:32] = merge_bytes(cmp_q[63:32], wmask, iob_wdat);
    end

    if (ctrl_wr) begin
      en_d  = ctrl_w[0];
      ie_d  = ctrl_w[1];
      div_d = ctrl_w[8 +: DIV_W];
    end

    // Prescaler restarts on CTRL writes, is parked while disabled, wraps at div
    if (ctrl_wr || !en_q || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + DIV_W'(1);
    end

    // Snapshot the upper word together with the lower word for tear-free reads
    if (rd && (sel == A_MTIME_LO)) begin
      shadow_d = mtime_q[63:32];
    end
  end

  assign irq_d = ie_q & match;

  // State and register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mtime_q  <= 64'h0;
      cmp_q    <= CMP_RST;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      div_q    <= '0;
      presc_q  <= '0;
      shadow_q <= 32'h0;
      rdy_q    <= 1'b0;
      rdat_q   <= 32'h0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      div_q    <= div_d;
      presc_q  <= presc_d;
      shadow_q <= shadow_d;
      rdy_q    <= rdy_d;
      rdat_q   <= rdat_d;
      irq_q    <= irq_d;
    end
  end

  assign iob_rdy   = rdy_q;
  assign iob_rdat  = rdat_q;
  assign timer_irq = irq_q;

endmodule

// File: tb/tb_cirno9_timer.sv
// Self-checking bench for cirno9_timer: expected read data is queued when a
// read is issued and compared when the DUT answers with iob_rdy.
module tb_cirno9_timer;

  localparam logic [31:0] A_LO   = 32'h00;
  localparam logic [31:0] A_HI   = 32'h04;
  localparam logic [31:0] A_CLO  = 32'h08;
  localparam logic [31:0] A_CHI  = 32'h0C;
  localparam logic [31:0] A_CTRL = 32'h10;
  localparam logic [31:0] A_STAT = 32'h14;
  localparam logic [31:0] A_R6   = 32'h18;
  localparam logic [31:0] A_R7   = 32'h1C;

  logic        clk;
  logic        rst;
  logic        iob_val;
  logic        iob_rdy;
  logic [31:0] iob_adr;
  logic [3:0]  iob_wen;
  logic [31:0] iob_wdat;
  logic [31:0] iob_rdat;
  logic        timer_irq;

  int          n_cmp;
  int          n_bad;
  logic [31:0] exp_q[$];
  logic        irq_at_rdy;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] d;

  cirno9_timer dut (
    .clk       (clk),
    .rst       (rst),
    .iob_val   (iob_val),
    .iob_rdy   (iob_rdy),
    .iob_adr   (iob_adr),
    .iob_wen   (iob_wen),
    .iob_wdat  (iob_wdat),
    .iob_rdat  (iob_rdat),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus access; starts and ends 1 time unit after a rising edge
  task automatic xfer(input logic [31:0] adr, input logic [3:0] wen,
                      input logic [31:0] wdat, output logic [31:0] rdata);
    iob_val  = 1'b1;
    iob_adr  = adr;
    iob_wen  = wen;
    iob_wdat = wdat;
    @(posedge clk); #1;
    chk("rdy_latency", iob_rdy, 1'b1);
    for (int k = 0; k < 8 && !iob_rdy; k++) begin
      @(posedge clk); #1;
    end
    rdata      = iob_rdat;
    irq_at_rdy = timer_irq;
    iob_val    = 1'b0;
    iob_wen    = 4'b0000;
    @(posedge clk); #1;
    chk("rdy_pulse", iob_rdy, 1'b0);
    $display("xfer adr=%h wen=%b wdat=%h rdat=%h", adr, wen, wdat, rdata);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [3:0] wen, input logic [31:0] wdat);
    logic [31:0] dummy;
    xfer(adr, wen, wdat, dummy);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] rdata);
    xfer(adr, 4'b0000, 32'h0, rdata);
  endtask

  // Scoreboarded read: expectation queued at issue, popped at response
  task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] got;
    exp_q.push_back(exp);
    rd(adr, got);
    chk(tag, got, exp_q.pop_front());
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_regs(input string pfx);
    rd_chk({pfx, "_mtime_lo"}, A_LO,   32'h0);
    rd_chk({pfx, "_mtime_hi"}, A_HI,   32'h0);
    rd_chk({pfx, "_cmp_lo"},   A_CLO,  32'hFFFF_FFFF);
    rd_chk({pfx, "_cmp_hi"},   A_CHI,  32'hFFFF_FFFF);
    rd_chk({pfx, "_ctrl"},     A_CTRL, 32'h0);
    rd_chk({pfx, "_status"},   A_STAT, 32'h0);
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    irq_at_rdy = 1'b0;
    rst        = 1'b1;
    iob_val    = 1'b0;
    iob_adr    = 32'h0;
    iob_wen    = 4'b0000;
    iob_wdat   = 32'h0;
    wait_cyc(3);
    chk("rst_rdy",  iob_rdy,   1'b0);
    chk("rst_rdat", iob_rdat,  32'h0);
    chk("rst_irq",  timer_irq, 1'b0);
    rst = 1'b0;
    wait_cyc(1);
    chk_reset_regs("reset");

    // Free-running at div 0: one tick per cycle
    wr(A_CTRL, 4'hF, 32'h1);
    rd(A_LO, a);
    wait_cyc(8);
    rd(A_LO, b);
    chk("div0_delta10", b - a, 32'd10);

    // div 3: one tick every 4 cycles
    wr(A_CTRL, 4'hF, 32'h0301);
    rd(A_LO, a);
    wait_cyc(8);
    rd(A_LO, b);
    d = b - a;
    chk("div3_delta10_2or3", (d == 32'd2) || (d == 32'd3), 1'b1);
    rd(A_LO, a);
    wait_cyc(98);
    rd(A_LO, b);
    chk("div3_delta100", b - a, 32'd25);

    // Carry from low to high word: exactly 2 ticks between enable and disable
    wr(A_CTRL, 4'hF, 32'h0);
    wr(A_LO, 4'hF, 32'hFFFF_FFFE);
    wr(A_HI, 4'hF, 32'h0);
    wr(A_CTRL, 4'hF, 32'h1);
    wr(A_CTRL, 4'hF, 32'h0);
    rd_chk("carry_lo", A_LO, 32'h0);
    rd_chk("carry_hi", A_HI, 32'h1);

    // Carry lands between the LO and HI reads; HI still returns the snapshot
    wr(A_LO, 4'hF, 32'hFFFF_FFFE);
    wr(A_HI, 4'hF, 32'h7);
    wr(A_CTRL, 4'hF, 32'h1);
    rd_chk("tear_lo", A_LO, 32'hFFFF_FFFF);
    rd_chk("tear_hi", A_HI, 32'h7);
    wr(A_CTRL, 4'hF, 32'h0);

    // Interrupt: mtime counts from 0 and reaches 0x20 after 32 ticks
    wr(A_LO, 4'hF, 32'h0);
    wr(A_HI, 4'hF, 32'h0);
    wr(A_CLO, 4'hF, 32'h20);
    wr(A_CHI, 4'hF, 32'h0);
    wr(A_CTRL, 4'hF, 32'h3);
    wait_cyc(31);
    chk("irq_before_match", timer_irq, 1'b0);
    wait_cyc(1);
    chk("irq_after_match", timer_irq, 1'b1);
    wr(A_CHI, 4'hF, 32'hFFFF_FFFF);
    chk("irq_held_at_cmp_write", irq_at_rdy, 1'b1);
    chk("irq_dropped", timer_irq, 1'b0);
    wr(A_CTRL, 4'hF, 32'h1);
    wr(A_CHI, 4'hF, 32'h0);
    wait_cyc(1);
    chk("irq_masked", timer_irq, 1'b0);
    rd_chk("status_match", A_STAT, 32'h1);

    // Reset asserted while the DUT is in RESP
    iob_val = 1'b1;
    iob_adr = A_LO;
    iob_wen = 4'b0000;
    @(posedge clk); #1;
    chk("resp_rdy", iob_rdy, 1'b1);
    rst     = 1'b1;
    iob_val = 1'b0;
    @(posedge clk); #1;
    chk("midrst_rdy", iob_rdy, 1'b0);
    chk("midrst_irq", timer_irq, 1'b0);
    rst = 1'b0;
    chk_reset_regs("midrst");

    // Byte strobes and unmapped addresses
    wr(A_CLO, 4'b0010, 32'h0000_AB00);
    rd_chk("byte_cmp_lo", A_CLO, 32'hFFFF_ABFF);
    wr(A_R6, 4'hF, 32'h1234_5678);
    rd_chk("r6_read",  A_R6,   32'h0);
    rd_chk("r7_read",  A_R7,   32'h0);
    rd_chk("r6_lo",    A_LO,   32'h0);
    rd_chk("r6_hi",    A_HI,   32'h0);
    rd_chk("r6_clo",   A_CLO,  32'hFFFF_ABFF);
    rd_chk("r6_chi",   A_CHI,  32'hFFFF_FFFF);
    rd_chk("r6_ctrl",  A_CTRL, 32'h0);
    rd_chk("r6_status",A_STAT, 32'h0);

    // Write beats tick: LO write edge W drops its tick, one tick at W+1 before
    // the read at W+2. HI write at W+6 drops that tick too (LO stays 0x1005),
    // then one tick at W+7 before the read at W+8.
    wr(A_HI, 4'hF, 32'h3);
    wr(A_CTRL, 4'hF, 32'h1);
    wr(A_LO, 4'hF, 32'h1000);
    rd_chk("wwin_lo", A_LO, 32'h1001);
    rd_chk("wwin_hi", A_HI, 32'h3);
    wr(A_HI, 4'hF, 32'h55);
    rd_chk("wwin_hi_lo", A_LO, 32'h1006);
    rd_chk("wwin_hi_hi", A_HI, 32'h55);
    wr(A_CTRL, 4'hF, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
